axi_btn_irq_v2: RTL and testbench

Parametrised successor to the single-register AXI4-Lite button peripheral. It accepts C_NUM_BTN asynchronous button/switch inputs and, per channel, synchronises, debounces and edge-detects them. It exposes debounced state, sticky edge status (write-1-to-clear), per-channel interrupt enables and mode control over an AXI4-Lite slave port, and drives one level interrupt to the PS.

---
 rtl/axi_btn_irq_v2.sv | 161 ++++++++++++++++
 tb/tb_axi_btn_irq_v2.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_btn_irq_v2.sv
// AXI4-Lite button peripheral: per-channel 2-flop sync, debounce, edge capture
// with W1C status, per-channel enables and a registered level interrupt.
module axi_btn_irq_v2 #(
  parameter int C_NUM_BTN            = 4,
  parameter int C_DEBOUNCE_CYCLES    = 1000000,
  parameter int C_DB_WIDTH           = 20,
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 4
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_NUM_BTN-1:0]              btn_in,
  output logic                              irq,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready
);

  localparam logic [C_DB_WIDTH-1:0] LP_DB_LAST = C_DB_WIDTH'(C_DEBOUNCE_CYCLES - 1);

  logic [C_NUM_BTN-1:0]  r_sync1, r_sync2, r_state, r_edge, r_irq_en;
  logic [2:0]            r_ctrl;
  logic [C_DB_WIDTH-1:0] r_cnt [C_NUM_BTN];
  logic                  r_awready, r_wready, r_bvalid, r_arready, r_rvalid, r_irq;
  logic [31:0]           r_rdata;

  logic                  w_wr_go, w_wr_hs, w_ar_go, w_rd_hs;
  logic [31:0]           w_wmask, w_wbits, w_rd_mux;
  logic [C_NUM_BTN-1:0]  w_toggle, w_set, w_clr, w_en_nxt;
  logic [2:0]            w_ctrl_nxt;
  logic                  w_unused;

  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                      s00_axi_araddr[1:0], w_wbits, w_wmask};

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  // A channel flips only after C_DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    w_toggle = '0;
    for (int i = 0; i < C_NUM_BTN; i++)
      w_toggle[i] = (r_sync2[i] != r_state[i]) && (r_cnt[i] == LP_DB_LAST);
  end

  assign w_set = w_toggle & ((~r_state & {C_NUM_BTN{r_ctrl[0]}}) |
                             ( r_state & {C_NUM_BTN{r_ctrl[1]}}));

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state <= '0;
      for (int i = 0; i < C_NUM_BTN; i++) r_cnt[i] <= '0;
    end else begin
      r_state <= r_state ^ w_toggle;
      for (int i = 0; i < C_NUM_BTN; i++) begin
        if (r_sync2[i] != r_state[i] && r_cnt[i] != LP_DB_LAST)
          r_cnt[i] <= r_cnt[i] + C_DB_WIDTH'(1);
        else
          r_cnt[i] <= '0;
      end
    end
  end

  assign w_wr_go = s00_axi_awvalid & s00_axi_wvalid & ~r_bvalid & ~r_awready;
  assign w_wr_hs = r_awready & r_wready & s00_axi_awvalid & s00_axi_wvalid;

  always_comb begin
    w_wmask = '0;
    for (int b = 0; b < 4; b++) w_wmask[8*b +: 8] = {8{s00_axi_wstrb[b]}};
  end

  assign w_wbits    = s00_axi_wdata & w_wmask;
  assign w_clr      = (w_wr_hs && s00_axi_awaddr[3:2] == 2'd1) ? w_wbits[C_NUM_BTN-1:0] : '0;
  assign w_en_nxt   = (r_irq_en & ~w_wmask[C_NUM_BTN-1:0]) | w_wbits[C_NUM_BTN-1:0];
  assign w_ctrl_nxt = (r_ctrl & ~w_wmask[2:0]) | w_wbits[2:0];

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_edge    <= '0;
      r_irq_en  <= '0;
      r_ctrl    <= 3'b011;
      r_irq     <= 1'b0;
    end else begin
      r_awready <= w_wr_go;
      r_wready  <= w_wr_go;
      if (w_wr_hs)             r_bvalid <= 1'b1;
      else if (s00_axi_bready) r_bvalid <= 1'b0;
      // New edges are OR-ed in after the clear so a coincident set survives.
      r_edge <= (r_edge & ~w_clr) | w_set;
      if (w_wr_hs && s00_axi_awaddr[3:2] == 2'd2) r_irq_en <= w_en_nxt;
      if (w_wr_hs && s00_axi_awaddr[3:2] == 2'd3) r_ctrl   <= w_ctrl_nxt;
      r_irq <= r_ctrl[2] & (|(r_edge & r_irq_en));
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (s00_axi_araddr[3:2])
      2'd0:    w_rd_mux[C_NUM_BTN-1:0] = r_state;
      2'd1:    w_rd_mux[C_NUM_BTN-1:0] = r_edge;
      2'd2:    w_rd_mux[C_NUM_BTN-1:0] = r_irq_en;
      default: w_rd_mux[2:0]           = r_ctrl;
    endcase
  end

  assign w_ar_go = s00_axi_arvalid & ~r_rvalid & ~r_arready;
  assign w_rd_hs = r_arready & s00_axi_arvalid;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= w_ar_go;
      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_mux;
      end else if (s00_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign s00_axi_awready = r_awready;
  assign s00_axi_wready  = r_wready;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = r_arready;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = 2'b00;
  assign irq             = r_irq;

endmodule

// File: tb/tb_axi_btn_irq_v2.sv
// Bench for axi_btn_irq_v2 with 4 channels and a 4-cycle debounce; a cycle
// model of the register file supplies expectations for the randomised rounds.
module tb_axi_btn_irq_v2;

  localparam int NB  = 4;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  btn_in = '0;
  logic        irq;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready;
  logic [31:0] wdata = '0, rdata;
  logic [3:0]  wstrb = '0;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready = 1'b1, arvalid = 1'b0, arready, rvalid, rready = 1'b1;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [3:0]  m_s1, m_s2, m_state, m_edge, m_en;
  logic [2:0]  m_ctrl;
  int          m_run [4];
  logic        m_irq;
  bit          wp;
  logic [1:0]  wp_addr;
  logic [31:0] wp_data;
  logic [3:0]  wp_strb;

  axi_btn_irq_v2 #(
    .C_NUM_BTN(NB), .C_DEBOUNCE_CYCLES(DEB), .C_DB_WIDTH(4),
    .C_S00_AXI_DATA_WIDTH(32), .C_S00_AXI_ADDR_WIDTH(4)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .btn_in(btn_in), .irq(irq),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_state = '0; m_edge = '0; m_en = '0;
    m_ctrl = 3'b011; m_irq = 1'b0; wp = 1'b0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  endtask

  // One clock of the behavioural model: a level flips after DEB consecutive
  // synchronised samples that disagree with it; edges use the old CTRL;
  // a pending write lands on this edge, with new edges winning over W1C.
  task automatic model_step();
    logic [3:0]  set, clr;
    logic [31:0] msk, bits;
    logic        irq_n;
    irq_n = m_ctrl[2] & (|(m_edge & m_en));
    set = '0;
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_state[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_run[i] = 0;
          m_state[i] = ~m_state[i];
          if ((m_state[i] && m_ctrl[0]) || (!m_state[i] && m_ctrl[1])) set[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = btn_in;
    clr = '0;
    if (wp) begin
      for (int b = 0; b < 4; b++) msk[8*b +: 8] = {8{wp_strb[b]}};
      bits = wp_data & msk;
      case (wp_addr)
        2'd1: clr = bits[3:0];
        2'd2: m_en = (m_en & ~msk[3:0]) | bits[3:0];
        2'd3: m_ctrl = (m_ctrl & ~msk[2:0]) | bits[2:0];
        default: ;
      endcase
      wp = 1'b0;
    end
    m_edge = (m_edge & ~clr) | set;
    m_irq = irq_n;
  endtask

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_state};
      2'd1:    return {28'd0, m_edge};
      2'd2:    return {28'd0, m_en};
      default: return {29'd0, m_ctrl};
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic irq_hs, output logic [1:0] resp);
    bit ok = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    irq_hs = 1'bx; resp = 2'bxx;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (awready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL write_timeout: awready never rose, addr %h", a);
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    wp = 1'b1; wp_addr = a[3:2]; wp_data = d; wp_strb = s;
    cyc();
    irq_hs = irq;
    awvalid = 1'b0; wvalid = 1'b0;
    resp = bvalid ? bresp : 2'bxx;
    cyc();
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output logic [31:0] exp);
    bit ok = 0;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    d = 'x; resp = 2'bxx; exp = 'x;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (arready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL read_timeout: arready never rose, addr %h", a);
      arvalid = 1'b0;
      return;
    end
    exp = m_reg(a[3:2]);
    cyc();
    arvalid = 1'b0;
    d = rvalid ? rdata : 'x;
    resp = rresp;
    cyc();
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    logic [1:0]  r;
    logic        ih;
    logic [31:0] exp_rst [4];
    exp_rst = '{32'h0, 32'h0, 32'h0, 32'h3};
    model_reset();
    repeat (3) cyc();
    checks++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake: got %b required 00000",
                         {awready, wready, bvalid, arready, rvalid});
    end
    checks++;
    if (rdata !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL reset_rdata_irq: rdata %h irq %b required 0 0", rdata, irq);
    end
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, r, e);
      checks++;
      if (d !== exp_rst[i] || r !== 2'b00) begin
        errors++; $display("FAIL reset_reg%0d: got %h resp %b required %h resp 00", i, d, r, exp_rst[i]);
      end
    end
    axi_write(4'h0, 32'hF, 4'hF, ih, r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL state_wr_resp: got %b required 00", r); end
    axi_read(4'h0, d, r, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL state_ro: got %h required 0", d); end
  endtask

  task automatic test_debounce();
    logic [31:0] d, e;
    logic [1:0]  r;
    btn_in[0] = 1'b1;
    repeat (4) cyc();
    axi_read(4'h0, d, r, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL btn0_early: got %h required 0", d); end
    repeat (3) cyc();
    axi_read(4'h0, d, r, e);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL btn0_state: got %h required 1", d); end
    axi_read(4'h4, d, r, e);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL btn0_edge: got %h required 1", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL btn0_irq_gie0: got %b required 0", irq); end
  endtask

  task automatic test_glitch();
    logic [31:0] d, e;
    logic [1:0]  r;
    logic        ih;
    btn_in[1] = 1'b1;
    repeat (3) cyc();
    btn_in[1] = 1'b0;
    repeat (10) cyc();
    axi_read(4'h0, d, r, e);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL glitch_state: got %h required 1", d); end
    axi_read(4'h4, d, r, e);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL glitch_edge: got %h required 1", d); end
    btn_in[1] = 1'b1;
    repeat (9) cyc();
    axi_read(4'h0, d, r, e);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL hold_state: got %h required 3", d); end
    axi_write(4'h4, 32'h2, 4'hF, ih, r);
    axi_read(4'h4, d, r, e);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL w1c_bit1: got %h required 1", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d, e;
    logic [1:0]  r;
    logic        ih;
    axi_write(4'h8, 32'h1, 4'hF, ih, r);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_no_gie: got %b required 0", irq); end
    axi_write(4'hC, 32'h7, 4'hF, ih, r);
    checks++;
    if (ih !== 1'b0 || irq !== 1'b1) begin
      errors++; $display("FAIL irq_assert: at_hs %b after %b required 0 1", ih, irq);
    end
    axi_write(4'h4, 32'h1, 4'hF, ih, r);
    checks++;
    if (ih !== 1'b1 || irq !== 1'b0) begin
      errors++; $display("FAIL irq_clear: at_hs %b after %b required 1 0", ih, irq);
    end
    axi_read(4'h4, d, r, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL edge_cleared: got %h required 0", d); end
  endtask

  task automatic test_fall_only();
    logic [31:0] d, e;
    logic [1:0]  r;
    logic        ih;
    axi_write(4'hC, 32'h6, 4'hF, ih, r);
    btn_in[2] = 1'b1;
    repeat (5) cyc();
    axi_read(4'h0, d, r, e);
    checks++;
    if (d !== 32'h7) begin errors++; $display("FAIL rise_state_exact: got %h required 7", d); end
    axi_read(4'h4, d, r, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rise_ignored: got %h required 0", d); end
    btn_in[2] = 1'b0;
    repeat (10) cyc();
    axi_read(4'h0, d, r, e);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL fall_state: got %h required 3", d); end
    axi_read(4'h4, d, r, e);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL fall_edge: got %h required 4", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL fall_irq_masked: got %b required 0", irq); end
    axi_write(4'h4, 32'h4, 4'hF, ih, r);
  endtask

  task automatic test_set_wins_and_strobes();
    logic [31:0] d, e;
    logic [1:0]  r;
    logic        ih;
    axi_write(4'hC, 32'h3, 4'hF, ih, r);
    btn_in[3] = 1'b1;
    repeat (10) cyc();
    axi_read(4'h4, d, r, e);
    checks++;
    if (d !== 32'h8) begin errors++; $display("FAIL btn3_rise_edge: got %h required 8", d); end
    btn_in[3] = 1'b0;
    repeat (4) cyc();
    axi_write(4'h4, 32'h8, 4'hF, ih, r);
    axi_read(4'h4, d, r, e);
    checks++;
    if (d !== 32'h8) begin errors++; $display("FAIL set_wins: got %h required 8", d); end
    axi_read(4'h0, d, r, e);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL btn3_fall_state: got %h required 3", d); end
    axi_write(4'h4, 32'h8, 4'hF, ih, r);
    axi_read(4'h4, d, r, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL plain_w1c: got %h required 0", d); end
    axi_write(4'h8, 32'hF, 4'h0, ih, r);
    axi_read(4'h8, d, r, e);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL wstrb_zero: got %h required 1", d); end
    axi_write(4'h8, 32'hFFFF_FFFF, 4'hF, ih, r);
    axi_read(4'h8, d, r, e);
    checks++;
    if (d !== 32'hF) begin errors++; $display("FAIL en_upper_bits: got %h required f", d); end
    axi_write(4'h8, 32'h0, 4'h2, ih, r);
    axi_read(4'h8, d, r, e);
    checks++;
    if (d !== 32'hF) begin errors++; $display("FAIL wstrb_byte1: got %h required f", d); end
    axi_write(4'hD, 32'hFFFF_FFF8, 4'hF, ih, r);
    axi_read(4'hE, d, r, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL ctrl_upper: got %h required 0", d); end
  endtask

  task automatic test_reset_midway();
    logic [31:0] d, e;
    logic [1:0]  r;
    awaddr = 4'h8; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    cyc();
    checks++;
    if (awready !== 1'b1) begin errors++; $display("FAIL mid_awready: got %b required 1", awready); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (awready !== 1'b0 || wready !== 1'b0) begin
      errors++; $display("FAIL async_drop: awready %b wready %b required 0 0", awready, wready);
    end
    model_reset();
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    axi_read(4'h8, d, r, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL mid_no_update: got %h required 0", d); end
    axi_read(4'hC, d, r, e);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL mid_ctrl: got %h required 3", d); end
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    logic [1:0]  r;
    logic        ih;
    for (int rnd = 0; rnd < 6; rnd++) begin
      axi_write(4'h8, 32'($urandom_range(0, 15)), 4'hF, ih, r);
      axi_write(4'hC, 32'($urandom_range(0, 7)), 4'hF, ih, r);
      for (int s = 0; s < 30; s++) begin
        btn_in = 4'($urandom);
        repeat ($urandom_range(1, 7)) cyc();
      end
      repeat (12) cyc();
      axi_read(4'h0, d, r, e);
      checks++;
      if (d !== e) begin errors++; $display("FAIL rand_state[%0d]: got %h required %h", rnd, d, e); end
      axi_read(4'h4, d, r, e);
      checks++;
      if (d !== e) begin errors++; $display("FAIL rand_edge[%0d]: got %h required %h", rnd, d, e); end
      checks++;
      if (irq !== m_irq) begin errors++; $display("FAIL rand_irq[%0d]: got %b required %b", rnd, irq, m_irq); end
      axi_write(4'h4, 32'hF, 4'hF, ih, r);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL rand_irq_clr[%0d]: got %b required 0", rnd, irq); end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_glitch();
    test_irq();
    test_fall_only();
    test_set_wins_and_strobes();
    test_reset_midway();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
